// File: rtl/cov_matrix_loader.sv
// Streams covariance elements into the shared LDL matrix, mirroring off-diagonals in symmetric mode.
// Element writes appear 1 cycle after accept; in_ready drops on mirror cycles and outside LOAD.
module cov_matrix_loader #(
  parameter int NUM_ROWS        = 169,
  parameter int WIDTH           = 32,
  parameter int SYMMETRIC_INPUT = 1,
  parameter int ROW_ADDR_WIDTH  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      initializing,
  output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
  output logic [ROW_ADDR_WIDTH-1:0] write_col_addr,
  output logic [WIDTH-1:0]          write_data,
  output logic                      write_ready,
  output logic                      start,
  input  logic                      finished,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_MIRROR = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_KICK   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam bit SYM = (SYMMETRIC_INPUT != 0);
  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_IDX = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

  logic [2:0]                state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] i_q, i_d;
  logic [ROW_ADDR_WIDTH-1:0] j_q, j_d;
  logic                      init_q, init_d;
  logic [ROW_ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [ROW_ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
  logic [WIDTH-1:0]          wr_data_q, wr_data_d;
  logic                      wr_vld_q, wr_vld_d;
  logic                      accept;
  logic                      last_elem;

  assign accept    = in_valid && (state_q == S_LOAD);
  assign last_elem = (i_q == LAST_IDX) && (j_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    wr_vld_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_row_d  = i_q;
          wr_col_d  = j_q;
          wr_data_d = in_data;
          wr_vld_d  = 1'b1;
          if (last_elem) begin
            // Counters hold at (N-1,N-1) so they never wrap past the matrix.
            state_d = S_FLUSH;
          end else begin
            if (j_q == LAST_IDX) begin
              i_d = i_q + 1'b1;
              j_d = SYM ? i_q + 1'b1 : '0;
            end else begin
              j_d = j_q + 1'b1;
            end
            state_d = (SYM && (i_q != j_q)) ? S_MIRROR : S_LOAD;
          end
        end
      end
      S_MIRROR: begin
        // The last element is always diagonal, so a mirror never ends the load.
        wr_row_d = wr_col_q;
        wr_col_d = wr_row_q;
        wr_vld_d = 1'b1;
        state_d  = S_LOAD;
      end
      S_FLUSH: state_d = S_KICK;
      S_KICK:  state_d = S_RUN;
      S_RUN: begin
        if (finished) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    init_d = (state_d == S_LOAD) || (state_d == S_MIRROR) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      init_q    <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      wr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      init_q    <= init_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      wr_vld_q  <= wr_vld_d;
    end
  end

  assign in_ready       = (state_q == S_LOAD);
  assign initializing   = init_q;
  assign write_row_addr = wr_row_q;
  assign write_col_addr = wr_col_q;
  assign write_data     = wr_data_q;
  assign write_ready    = wr_vld_q;
  assign start          = (state_q == S_KICK);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_cov_matrix_loader.sv
`timescale 1ns/1ps
module tb_cov_matrix_loader;

  typedef struct { int r; int c; int d; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, load_start, in_valid, finished;
  logic [31:0] in_data;
  logic [1:0]  sel;

  logic [2:0]  ls, iv, fin;
  logic [2:0]  rdy, ini, wv, st, bz, dn;
  logic [1:0]  r0, c0, r1, c1;
  logic [7:0]  r2, c2;
  logic [31:0] wd0, wd1, wd2;

  assign ls  = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{load_start}};
  assign iv  = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{in_valid}};
  assign fin = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{finished}};

  cov_matrix_loader #(.NUM_ROWS(4), .WIDTH(32), .SYMMETRIC_INPUT(1)) u_s4 (
    .clk(clk), .rst(rst), .load_start(ls[0]), .in_data(in_data), .in_valid(iv[0]),
    .in_ready(rdy[0]), .initializing(ini[0]), .write_row_addr(r0), .write_col_addr(c0),
    .write_data(wd0), .write_ready(wv[0]), .start(st[0]), .finished(fin[0]),
    .busy(bz[0]), .done(dn[0]));

  cov_matrix_loader #(.NUM_ROWS(4), .WIDTH(32), .SYMMETRIC_INPUT(0)) u_f4 (
    .clk(clk), .rst(rst), .load_start(ls[1]), .in_data(in_data), .in_valid(iv[1]),
    .in_ready(rdy[1]), .initializing(ini[1]), .write_row_addr(r1), .write_col_addr(c1),
    .write_data(wd1), .write_ready(wv[1]), .start(st[1]), .finished(fin[1]),
    .busy(bz[1]), .done(dn[1]));

  cov_matrix_loader #(.NUM_ROWS(169), .WIDTH(32), .SYMMETRIC_INPUT(1)) u_s169 (
    .clk(clk), .rst(rst), .load_start(ls[2]), .in_data(in_data), .in_valid(iv[2]),
    .in_ready(rdy[2]), .initializing(ini[2]), .write_row_addr(r2), .write_col_addr(c2),
    .write_data(wd2), .write_ready(wv[2]), .start(st[2]), .finished(fin[2]),
    .busy(bz[2]), .done(dn[2]));

  logic        c_rdy, c_ini, c_wv, c_st, c_bz, c_dn;
  logic [31:0] c_row, c_col, c_wd;

  always_comb begin
    c_rdy = rdy[sel]; c_ini = ini[sel]; c_wv = wv[sel];
    c_st  = st[sel];  c_bz  = bz[sel];  c_dn = dn[sel];
    c_row = 32'(r0); c_col = 32'(c0); c_wd = wd0;
    case (sel)
      2'd1:    begin c_row = 32'(r1); c_col = 32'(c1); c_wd = wd1; end
      2'd2:    begin c_row = 32'(r2); c_col = 32'(c2); c_wd = wd2; end
      default: begin c_row = 32'(r0); c_col = 32'(c0); c_wd = wd0; end
    endcase
  end

  int  checks = 0, errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  got [0:168][0:168];
  int  wcnt[0:168][0:168];
  int  expm[0:168][0:168];
  int  el_i[$], el_j[$];
  int  start_cnt = 0, done_cnt = 0, nwrites = 0, first_wr_cyc = 0, last_wr_cyc = 0;

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (c_wv === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got row=%0d col=%0d data=%0d, required no write", c_row, c_col, c_wd);
      end else begin
        mon_e = exp_q.pop_front();
        if (c_row != 32'(mon_e.r) || c_col != 32'(mon_e.c) || c_wd != 32'(mon_e.d)) begin
          errors++;
          $display("FAIL write: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   c_row, c_col, c_wd, mon_e.r, mon_e.c, mon_e.d);
        end
      end
      if (c_row < 169 && c_col < 169) begin
        got[c_row][c_col] = int'(c_wd);
        wcnt[c_row][c_col]++;
      end
      if (nwrites == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      nwrites++;
    end
    if (c_st === 1'b1) begin
      start_cnt++;
      checks++;
      if (c_ini !== 1'b0) begin
        errors++;
        $display("FAIL init_with_start: got initializing=%0b, required 0", c_ini);
      end
    end
    if (c_dn === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int outs_vec();
    return int'({c_rdy, c_ini, c_wv, c_st, c_bz, c_dn}) | int'(c_row) | int'(c_col) | int'(c_wd);
  endfunction

  task automatic run_load(input int n, input bit sym, input bit gaps, input int abort_after,
                          input int inject_at, input int fin_delay);
    int k, total, target, lowcnt, last_acc, first_acc, s0, d0, tmo, bad;
    bit inj_done;
    sel = (n == 169) ? 2'd2 : (sym ? 2'd0 : 2'd1);
    el_i.delete(); el_j.delete();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        got[r][c] = -1; wcnt[r][c] = 0; expm[r][c] = -2;
      end
    for (int r = 0; r < n; r++)
      for (int c = (sym ? r : 0); c < n; c++) begin
        expm[r][c] = el_i.size();
        if (sym) expm[c][r] = el_i.size();
        el_i.push_back(r); el_j.push_back(c);
      end
    total  = el_i.size();
    target = (abort_after > 0) ? abort_after : total;
    nwrites = 0; s0 = start_cnt; d0 = done_cnt;
    lowcnt = 0; last_acc = 0; first_acc = 0; inj_done = 1'b0;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    k = 0; tmo = 0;
    while (k < target && tmo < 4 * total + 20) begin
      tmo++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? 32'(k) : $urandom;
      if (!inj_done && k == inject_at) begin
        load_start = 1'b1; finished = 1'b1; inj_done = 1'b1;
      end else begin
        load_start = 1'b0; finished = 1'b0;
      end
      if (c_rdy !== 1'b1) lowcnt++;
      if (in_valid && c_rdy === 1'b1) begin
        exp_q.push_back('{el_i[k], el_j[k], k});
        if (sym && el_i[k] != el_j[k]) exp_q.push_back('{el_j[k], el_i[k], k});
        if (k == 0) first_acc = cyc;
        last_acc = cyc;
        k++;
      end
      @(negedge clk);
    end
    load_start = 1'b0; finished = 1'b0;
    check("accepted_elements", k, target);
    if (abort_after > 0) begin
      // Reset while an acceptance would otherwise happen on this edge.
      rst = 1'b1; in_valid = 1'b1; in_data = 32'(k);
      @(negedge clk);
      check("outputs_after_abort", outs_vec(), 0);
      rst = 1'b0; in_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("start_after_abort", start_cnt - s0, 0);
      check("done_after_abort", done_cnt - d0, 0);
      check("pending_after_abort", exp_q.size(), 0);
      return;
    end
    in_valid = 1'b0;
    check("in_ready_low_cycles", lowcnt, sym ? n * (n - 1) / 2 : 0);
    tmo = 0;
    while (c_st !== 1'b1 && tmo < 20) begin
      @(negedge clk); tmo++;
    end
    check("start_seen", int'(c_st === 1'b1), 1);
    check("start_latency", cyc - last_acc, 2);
    @(negedge clk);
    bad = 0;
    for (int d = 0; d < fin_delay; d++) begin
      if (c_bz !== 1'b1 || c_dn !== 1'b0) bad++;
      @(negedge clk);
    end
    check("busy_while_running", bad, 0);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    check("done_pulse", int'(c_dn === 1'b1), 1);
    @(negedge clk);
    check("idle_after_done", int'({c_dn, c_bz}), 0);
    check("writes_outstanding", exp_q.size(), 0);
    check("write_count", nwrites, n * n);
    if (!sym && !gaps) begin
      check("first_write_cycle", first_wr_cyc - first_acc, 1);
      check("write_span", last_wr_cyc - first_wr_cyc, total - 1);
    end
    bad = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (wcnt[r][c] != 1 || got[r][c] != expm[r][c]) bad++;
    check("matrix_contents", bad, 0);
    check("starts_per_load", start_cnt - s0, 1);
    check("dones_per_load", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; finished = 1'b0;
    in_data = '0; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 0);

    run_load(4, 1'b1, 1'b0, 0, -1, 3);
    run_load(4, 1'b0, 1'b0, 0, -1, 3);
    run_load(4, 1'b1, 1'b1, 0, -1, 3);
    run_load(4, 1'b1, 1'b0, 0, -1, 100);
    run_load(4, 1'b1, 1'b0, 5, -1, 0);
    run_load(4, 1'b1, 1'b0, 0, -1, 3);
    run_load(4, 1'b1, 1'b1, 0, 4, 3);
    run_load(4, 1'b0, 1'b1, 0, 7, 2);
    run_load(169, 1'b1, 1'b0, 0, -1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
